// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;
   localparam int DEF_DW = 8;
   localparam int DEF_DIV_W = 16;
   localparam int MIN_DIV = 2;
   typedef enum logic [2:0] {IDLE, WAIT, START, DATA, STOP} state_t;
endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read-port handshake between the transmitter (master) and the FIFO (slave).
interface fifo_uart_tx_if
   import fifo_uart_pkg::*;
#(
   parameter int DW = DEF_DW
);
   logic empty_in;
   logic r_en_out;
   logic [DW-1:0] r_data_in;
   modport master (input empty_in, input r_data_in, output r_en_out);
   modport slave (output empty_in, output r_data_in, input r_en_out);
endinterface

// File: rtl/fifo_uart_tx_baud_cnt.sv
// uart_baud_cnt: latches the clamped divisor at frame start and pulses bit_done at the end of every bit.
module uart_baud_cnt
   import fifo_uart_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             r_clk,
   input  logic             r_rst_n_in,
   input  logic             load,
   input  logic             run,
   input  logic [DIV_W-1:0] baud_div,
   output logic             bit_done
);
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] cnt;
   assign bit_done = run && cnt == div_q - DIV_W'(1);
   always_ff @(posedge r_clk or negedge r_rst_n_in) begin
      if (!r_rst_n_in) begin
         div_q <= '0;
         cnt <= '0;
      end else if (load) begin
         div_q <= baud_div < DIV_W'(MIN_DIV) ? DIV_W'(MIN_DIV) : baud_div;
         cnt <= '0;
      end else if (run) begin
         cnt <= bit_done ? '0 : cnt + DIV_W'(1);
      end
   end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls bytes from a FIFO and sends them as 8N1 frames, LSB first, idle-high line.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             r_clk,
   input  logic             r_rst_n_in,
   input  logic             tx_enable,
   input  logic [DIV_W-1:0] baud_div,
   fifo_uart_tx_if.master   fifo,
   output logic             tx_out,
   output logic             busy_out,
   output logic [15:0]      frame_cnt_out
);
   localparam int IDX_W = DW > 1 ? $clog2(DW) : 1;
   state_t state;
   logic [DW-1:0] sh;
   logic [IDX_W-1:0] idx;
   logic bit_done;
   // Gated by reset so no read is issued while the block is held in reset.
   assign fifo.r_en_out = r_rst_n_in && state == IDLE && tx_enable && !fifo.empty_in;
   assign busy_out = state != IDLE;
   uart_baud_cnt #(.DIV_W(DIV_W)) u_baud (
      .r_clk      (r_clk),
      .r_rst_n_in (r_rst_n_in),
      .load       (state == WAIT),
      .run        (state inside {START, DATA, STOP}),
      .baud_div   (baud_div),
      .bit_done   (bit_done)
   );
   always_ff @(posedge r_clk or negedge r_rst_n_in) begin
      if (!r_rst_n_in) begin
         state <= IDLE;
         tx_out <= 1'b1;
         sh <= '0;
         idx <= '0;
         frame_cnt_out <= '0;
      end else begin
         case (state)
            IDLE: if (fifo.r_en_out) state <= WAIT;
            WAIT: begin
               sh <= fifo.r_data_in;
               tx_out <= 1'b0;
               state <= START;
            end
            START: if (bit_done) begin
               tx_out <= sh[0];
               sh <= sh >> 1;
               idx <= '0;
               state <= DATA;
            end
            DATA: if (bit_done) begin
               if (idx == IDX_W'(DW - 1)) begin
                  tx_out <= 1'b1;
                  state <= STOP;
               end else begin
                  tx_out <= sh[0];
                  sh <= sh >> 1;
                  idx <= idx + IDX_W'(1);
               end
            end
            STOP: if (bit_done) begin
               frame_cnt_out <= frame_cnt_out + 16'd1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench with a FIFO model and a byte scoreboard checked against the serial line.
module tb_fifo_uart_tx;
   logic r_clk = 1'b0;
   logic r_rst_n_in;
   logic tx_enable;
   logic [15:0] baud_div;
   logic tx_out;
   logic busy_out;
   logic [15:0] frame_cnt_out;
   fifo_uart_tx_if #(.DW(8)) ifc ();
   fifo_uart_tx #(.DW(8), .DIV_W(16)) dut (
      .r_clk         (r_clk),
      .r_rst_n_in    (r_rst_n_in),
      .tx_enable     (tx_enable),
      .baud_div      (baud_div),
      .fifo          (ifc),
      .tx_out        (tx_out),
      .busy_out      (busy_out),
      .frame_cnt_out (frame_cnt_out)
   );
   always #5 r_clk = ~r_clk;
   logic [7:0] mem [256];
   logic [7:0] wr_ptr = 8'd0;
   logic [7:0] rd_ptr = 8'd0;
   logic [7:0] rdata = 8'd0;
   int ren_cnt = 0;
   int ren_viol = 0;
   assign ifc.empty_in = wr_ptr == rd_ptr;
   assign ifc.r_data_in = rdata;
   always @(posedge r_clk) begin
      if (ifc.r_en_out) begin
         if (ifc.empty_in) ren_viol <= ren_viol + 1;
         rdata <= mem[rd_ptr];
         rd_ptr <= rd_ptr + 8'd1;
         ren_cnt <= ren_cnt + 1;
      end
   end
   logic [7:0] sb [$];
   int pass_n = 0;
   int total_n = 0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_n++;
      assert (obs === exp) pass_n++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   task automatic push(input logic [7:0] b, input bit expect_it);
      mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 8'd1;
      if (expect_it) sb.push_back(b);
   endtask
   // Finds the next start bit, then checks every cycle of the frame against the expected 10-bit pattern.
   task automatic rx_check(input int div, output int lead);
      logic [9:0] bits;
      logic [7:0] exp;
      logic [7:0] got;
      int bad;
      int t;
      lead = 0;
      t = 0;
      @(negedge r_clk);
      while (tx_out === 1'b1 && t < 500) begin
         lead++;
         t++;
         @(negedge r_clk);
      end
      if (t >= 500) begin
         chk("rx_start_timeout", {31'd0, tx_out}, 32'd0);
         return;
      end
      if (sb.size() == 0) begin
         chk("sb_underflow", 32'd0, 32'd1);
         return;
      end
      exp = sb.pop_front();
      bits = {1'b1, exp, 1'b0};
      bad = 0;
      got = 8'd0;
      for (int i = 0; i < 10 * div; i++) begin
         if (tx_out !== bits[i / div]) bad++;
         if (i % div == div / 2 && i / div >= 1 && i / div <= 8) got[i / div - 1] = tx_out;
         if (i != 10 * div - 1) @(negedge r_clk);
      end
      chk("frame_shape", bad, 0);
      chk("frame_data", {24'd0, got}, {24'd0, exp});
   endtask
   initial begin
      int l1, l2, l3, dummy, bad, t, ren0;
      r_rst_n_in = 1'b0;
      tx_enable = 1'b1;
      baud_div = 16'd4;
      push(8'hA5, 1'b1);
      repeat (3) @(negedge r_clk);
      #1;
      chk("rst_tx", {31'd0, tx_out}, 32'd1);
      chk("rst_busy", {31'd0, busy_out}, 32'd0);
      chk("rst_cnt", {16'd0, frame_cnt_out}, 32'd0);
      chk("rst_ren", {31'd0, ifc.r_en_out}, 32'd0);
      @(negedge r_clk);
      r_rst_n_in = 1'b1;
      rx_check(4, dummy);
      @(negedge r_clk);
      chk("single_cnt", {16'd0, frame_cnt_out}, 32'd1);
      chk("single_ren", ren_cnt, 1);
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge r_clk);
         if (ifc.r_en_out || busy_out || !tx_out) bad++;
      end
      chk("empty_hold", bad, 0);
      baud_div = 16'd3;
      push(8'h01, 1'b1);
      push(8'h80, 1'b1);
      push(8'hFF, 1'b1);
      rx_check(3, l1);
      rx_check(3, l2);
      rx_check(3, l3);
      chk("b2b_gap2", l2, 2);
      chk("b2b_gap3", l3, 2);
      @(negedge r_clk);
      chk("b2b_cnt", {16'd0, frame_cnt_out}, 32'd4);
      chk("b2b_ren", ren_cnt, 4);
      push(8'h3C, 1'b1);
      push(8'h55, 1'b0);
      fork
         rx_check(3, dummy);
         begin
            t = 0;
            while (!busy_out && t < 200) begin
               t++;
               @(negedge r_clk);
            end
            repeat (14) @(negedge r_clk);
            tx_enable = 1'b0;
         end
      join
      repeat (100) @(negedge r_clk);
      chk("drop_ren", ren_cnt, 5);
      chk("drop_busy", {31'd0, busy_out}, 32'd0);
      chk("drop_cnt", {16'd0, frame_cnt_out}, 32'd5);
      tx_enable = 1'b1;
      t = 0;
      @(negedge r_clk);
      while (!busy_out && t < 200) begin
         t++;
         @(negedge r_clk);
      end
      repeat (8) @(negedge r_clk);
      #2;
      r_rst_n_in = 1'b0;
      #1;
      chk("midrst_tx", {31'd0, tx_out}, 32'd1);
      chk("midrst_busy", {31'd0, busy_out}, 32'd0);
      chk("midrst_cnt", {16'd0, frame_cnt_out}, 32'd0);
      @(negedge r_clk);
      r_rst_n_in = 1'b1;
      ren0 = ren_cnt;
      push(8'h96, 1'b1);
      rx_check(3, dummy);
      @(negedge r_clk);
      chk("postrst_cnt", {16'd0, frame_cnt_out}, 32'd1);
      chk("postrst_ren", ren_cnt - ren0, 1);
      force dut.frame_cnt_out = 16'hFFFF;
      @(negedge r_clk);
      release dut.frame_cnt_out;
      baud_div = 16'd0;
      push(8'h5A, 1'b1);
      rx_check(2, dummy);
      @(negedge r_clk);
      chk("wrap_cnt", {16'd0, frame_cnt_out}, 32'd0);
      chk("ren_empty_viol", ren_viol, 0);
      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter: DW, 8, data width of the FIFO read port and of the serial frame.
REQ-002 Parameter: DIV_W, 16, width of the baud divisor.
REQ-003 Port: r_clk  in  1  read-domain clock; all logic is on its rising edge.
REQ-004 Port: r_rst_n_in  in  1  reset, asynchronous assert, active-low.
REQ-005 Port: tx_enable  in  1  permits new frames to start.
REQ-006 Port: baud_div  in  DIV_W  r_clk cycles per serial bit.
REQ-007 Port: empty_in  in  1  FIFO empty flag.
REQ-008 Port: r_data_in  in  DW  FIFO read data, valid on the cycle after an accepted read.
REQ-009 Port: r_en_out  out  1  FIFO read request.
REQ-010 Port: tx_out  out  1  serial line; 8N1 format, LSB first, idle high.
REQ-011 Port: busy_out  out  1  high whenever the state is not IDLE.
REQ-012 Port: frame_cnt_out  out  16  count of completed frames.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, START, DATA and STOP.
REQ-014 r_en_out SHALL equal (state==IDLE && tx_enable && !empty_in); it is combinational, never high while empty_in=1, and high for at most one cycle per frame.
REQ-015 IDLE SHALL go to WAIT on any edge where r_en_out=1.
REQ-016 WAIT SHALL last exactly one cycle; at its closing edge r_data_in is loaded into the shift register, baud_div is latched, tx_out goes to 0, and the state goes to START.
REQ-017 Latched divisor: values 0 and 1 SHALL be treated as 2.
REQ-018 Bit timing: START, each of the DW DATA bits and STOP SHALL each hold tx_out for exactly the latched divisor number of cycles.
REQ-019 Frame length SHALL be (DW+2)*div cycles.
REQ-020 DATA SHALL shift LSB first, using a bit index counter from 0 to DW-1.
REQ-021 STOP SHALL drive tx_out=1; at the end of STOP, frame_cnt_out increments (wrapping 0xFFFF->0x0000) and the state goes to IDLE.
REQ-022 Back-to-back frames: the minimum gap between the stop-bit end and the next start-bit edge SHALL be 2 cycles (IDLE + WAIT).
REQ-023 Deasserting tx_enable mid-frame SHALL NOT abort the frame; it only blocks the next read.
REQ-024 A change of baud_div mid-frame SHALL take effect only at the next WAIT.
REQ-025 empty_in rising during WAIT SHALL NOT affect the frame, because the read was already accepted.
REQ-026 tx_out SHALL be registered (glitch-free).

Reset
REQ-027 On reset assertion, asynchronously: state=IDLE, tx_out=1, busy_out=0, frame_cnt_out=0, shift register=0, counters=0, r_en_out=0.
REQ-028 Reset mid-frame SHALL truncate the frame with the line immediately high; the byte in flight is lost and is not re-read.
REQ-029 After reset release, the first r_en_out SHALL occur no earlier than the first edge after release.

Structure
REQ-030 Package fifo_uart_pkg SHALL hold: the state enum type, default DW/DIV_W constants, and MIN_DIV=2.
REQ-031 Sub-module uart_baud_cnt SHALL hold the divisor latch, cycle counter and bit_done pulse; the FSM and shifter stay in fifo_uart_tx.

Verification
REQ-032 Single byte: baud_div=4, FIFO holds 0xA5, tx_enable=1 -> one r_en_out pulse; tx_out=0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit; frame_cnt_out=1.
REQ-033 Empty hold: empty_in=1 for 200 cycles, tx_enable=1 -> r_en_out and busy_out are never high; tx_out stays 1.
REQ-034 Back-to-back: bytes 0x01, 0x80, 0xFF with baud_div=3 -> three frames, 30 cycles each, 2-cycle gaps; bytes in order; frame_cnt_out=3; scoreboard matches the FIFO write order.
REQ-035 Enable drop: tx_enable falls during bit 3 of 0x3C -> the frame completes intact and no further r_en_out occurs.
REQ-036 Reset mid-frame: r_rst_n_in low during DATA -> same cycle tx_out=1, busy_out=0, frame_cnt_out=0; after release the next byte transmits correctly.
REQ-037 Divisor clamp and wrap: baud_div=0 -> 2-cycle bits; preload frame_cnt_out to 0xFFFF via 65535 frames or a force -> the next frame gives 0x0000.
